adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter WIDTH, default 32: operand width; only 32 is supported.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port req_valid, input, NREQ: bit i set = requester i offers an operand pair.
REQ-006 Port req_ready, output, NREQ: bit i set = requester i granted this cycle.
REQ-007 Port req_a, input, NREQ*WIDTH: operand A; requester i uses slice [i*WIDTH +: WIDTH].
REQ-008 Port req_b, input, NREQ*WIDTH: operand B; same slicing as req_a.
REQ-009 Port rsp_valid, output, 1: result register holds a valid result.
REQ-010 Port rsp_ready, input, 1: consumer accepts the result.
REQ-011 Port rsp_id, output, $clog2(NREQ): index of the requester owning the result.
REQ-012 Port rsp_sum, output, WIDTH: (a+b) mod 2^WIDTH.
REQ-013 Port rsp_cout, output, 1: carry out of a+b.

Function
REQ-014 One kogge_stone_adder instance (WIDTH=32) is shared by all requesters; no other adder exists.
REQ-015 Handshake: requester transfer when req_valid[i] & req_ready[i]; response transfer when rsp_valid & rsp_ready.
REQ-016 Requesters hold req_valid and operands until granted; req_ready never depends combinationally on rsp_valid of another requester's side-effects beyond REQ-018.
REQ-017 req_ready is one-hot or zero; at most one grant per cycle.
REQ-018 Grant allowed in a cycle iff !rsp_valid | rsp_ready (result register empty or draining).
REQ-019 Arbitration is round-robin: the search starts at index ptr, ptr+1, ... mod NREQ; the first valid index wins.
REQ-020 After a grant to index k, ptr <= (k+1) mod NREQ; with no grant, ptr holds.
REQ-021 Latency is 1 cycle: the grant in cycle n gives rsp_valid=1 with sum/cout/id in cycle n+1.
REQ-022 Throughput: one result per cycle when rsp_ready is held high.
REQ-023 Output state machine states:
- EMPTY: rsp_valid=0.
- FULL: rsp_valid=1.
REQ-024 Output state transitions:
- EMPTY->FULL on grant.
- FULL->EMPTY on rsp_ready with no grant.
- FULL->FULL on grant with rsp_ready: new result loaded.
- Otherwise hold.
REQ-025 While FULL with rsp_ready=0, rsp_sum/rsp_cout/rsp_id are stable.
REQ-026 Simultaneous drain and grant in the same cycle loses no result and duplicates none.
REQ-027 Wrap-around: 0xFFFFFFFF+1 gives sum=0, cout=1.

Reset
REQ-028 On rst_n low, immediately: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0, req_ready=0.
REQ-029 Reset mid-operation discards any pending result; the first grant after release starts the search at index 0.
REQ-030 rst_n deassertion is synchronised externally; the block has no internal synchroniser.

Configuration
REQ-031 Macro ADDER_ARBITER_STATS_EN, when defined, adds output stat_grants, NREQ*16 bits.
REQ-032 stat_grants holds one saturating 16-bit grant counter per requester; counter i increments on each grant to i and resets to 0.
REQ-033 With ADDER_ARBITER_STATS_EN undefined, neither port nor counters exist; behaviour is otherwise identical.

Verification
REQ-034 Single request: req0 a=0x00000005, b=0x00000003 -> next cycle rsp_valid=1, sum=0x00000008, cout=0, id=0.
REQ-035 Overflow: req2 a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, id=2.
REQ-036 Fairness: all 4 valid continuously, rsp_ready=1 -> ids 0,1,2,3,0,1,... with one result per cycle.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles with requests pending -> no req_ready, result stable; rsp_ready=1 -> drain and new grant in the same cycle.
REQ-038 Reset mid-stream: rst_n low while FULL -> rsp_valid=0 at once; after release with reqs 1 and 3 valid -> first grant is 1.
REQ-039 Stats (macro defined): 70000 grants to req1 -> stat_grants[1] saturates at 0xFFFF; the other counters stay 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// ============================================================================
//  Module   : adder_arbiter (with helper kogge_stone_adder)
//  Brief    : Round-robin arbiter sharing one Kogge-Stone adder among NREQ
//             requesters; one registered result slot with valid/ready drain.
//             Optional per-requester grant counters: ADDER_ARBITER_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kogge_stone_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int c_levels = $clog2(WIDTH);

  logic [WIDTH-1:0] w_g [0:c_levels];
  logic [WIDTH-1:0] w_p [0:c_levels-1];

  assign w_g[0] = i_a & i_b;
  assign w_p[0] = i_a ^ i_b;

  // Bits below the span of a level pass straight through: g gets zero, p gets ones.
  for (genvar l = 0; l < c_levels; l++) begin : g_level
    localparam int               c_dist     = 1 << l;
    localparam logic [WIDTH-1:0] c_low_mask = WIDTH'((64'd1 << c_dist) - 64'd1);

    assign w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << c_dist));

    if (l < c_levels - 1) begin : g_prop
      assign w_p[l+1] = w_p[l] & ((w_p[l] << c_dist) | c_low_mask);
    end
  end

  assign o_sum  = w_p[0] ^ {w_g[c_levels][WIDTH-2:0], 1'b0};
  assign o_cout = w_g[c_levels][WIDTH-1];

endmodule

module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_cout
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [NREQ*16-1:0]        stat_grants
`endif
);

  localparam int c_idw = $clog2(NREQ);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_idw-1:0] r_ptr;

  logic [c_idw-1:0] w_pick_id;
  logic             w_pick_found;
  logic             w_can_grant;
  logic             w_fire;
  logic [c_idw-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // Round-robin search starting at r_ptr; the extra index bit absorbs the wrap.
  always_comb begin
    logic [c_idw:0] v_idx;
    v_idx        = '0;
    w_pick_id    = '0;
    w_pick_found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      v_idx = {1'b0, r_ptr} + (c_idw+1)'(off);
      if (v_idx >= (c_idw+1)'(NREQ)) begin
        v_idx = v_idx - (c_idw+1)'(NREQ);
      end
      if (!w_pick_found && req_valid[v_idx[c_idw-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_id    = v_idx[c_idw-1:0];
      end
    end
  end

  assign w_can_grant = (r_state == S_EMPTY) || rsp_ready;
  assign w_fire      = w_pick_found && w_can_grant;
  assign w_ptr_next  = (w_pick_id == c_idw'(NREQ - 1)) ? '0 : w_pick_id + c_idw'(1);

  // Gated by rst_n so no grant is visible while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (w_fire && rst_n) begin
      req_ready[w_pick_id] = 1'b1;
    end
  end

  assign w_op_a = req_a[w_pick_id*WIDTH +: WIDTH];
  assign w_op_b = req_b[w_pick_id*WIDTH +: WIDTH];

  kogge_stone_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_ptr    <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_fire) r_state <= S_FULL;
        end
        S_FULL: begin
          if (w_fire)         r_state <= S_FULL;
          else if (rsp_ready) r_state <= S_EMPTY;
        end
        default: r_state <= S_EMPTY;
      endcase
      if (w_fire) begin
        rsp_sum  <= w_sum;
        rsp_cout <= w_cout;
        rsp_id   <= w_pick_id;
        r_ptr    <= w_ptr_next;
      end
    end
  end

  assign rsp_valid = (r_state == S_FULL);

`ifdef ADDER_ARBITER_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (req_ready[gi] && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end

    assign stat_grants[gi*16 +: 16] = r_count;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
//  Module   : tb_adder_arbiter
//  Brief    : Scoreboard bench for adder_arbiter with a queue-based reference.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
`ifdef ADDER_ARBITER_STATS_EN
  logic [NREQ*16-1:0]    stat_grants;
`endif

  always #5 clk = ~clk;

  adder_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout)
`ifdef ADDER_ARBITER_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } rsp_t;

  rsp_t            sb[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              ptr_m    = 0;
  bit              full_m   = 1'b0;
  int              grants_m[NREQ];
  logic [NREQ-1:0] last_grant;
  bit              done     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (rst_n && !done) begin
        check("rsp_valid_vs_sb", {63'd0, rsp_valid}, {63'd0, (sb.size() != 0)});
        if (rsp_valid && sb.size() != 0) begin
          check("rsp_id",   {62'd0, rsp_id},   {62'd0, sb[0].id});
          check("rsp_sum",  {32'd0, rsp_sum},  {32'd0, sb[0].sum});
          check("rsp_cout", {63'd0, rsp_cout}, {63'd0, sb[0].cout});
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Called at the drive point of a cycle; checks the grant and advances one cycle.
  task automatic step();
    int               k;
    bit               allow;
    logic [NREQ-1:0]  exp_rdy;
    logic [WIDTH:0]   s;
    rsp_t             e;
    #4;
    check("rsp_valid", {63'd0, rsp_valid}, {63'd0, full_m});
    allow = !full_m || rsp_ready;
    k = -1;
    for (int off = 0; off < NREQ; off++) begin
      if (k < 0 && req_valid[(ptr_m + off) % NREQ]) k = (ptr_m + off) % NREQ;
    end
    exp_rdy = '0;
    if (allow && k >= 0) exp_rdy[k] = 1'b1;
    check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    last_grant = exp_rdy;
    if (allow && k >= 0) begin
      s      = {1'b0, req_a[k*WIDTH +: WIDTH]} + {1'b0, req_b[k*WIDTH +: WIDTH]};
      e.id   = IDW'(k);
      e.sum  = s[WIDTH-1:0];
      e.cout = s[WIDTH];
      sb.push_back(e);
      ptr_m  = (k + 1) % NREQ;
      full_m = 1'b1;
      if (grants_m[k] < 65535) grants_m[k]++;
    end else if (rsp_ready) begin
      full_m = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_sum",   {32'd0, rsp_sum},   64'd0);
    check("rst_rsp_cout",  {63'd0, rsp_cout},  64'd0);
    check("rst_rsp_id",    {62'd0, rsp_id},    64'd0);
    check("rst_req_ready", {60'd0, req_ready}, 64'd0);
    sb.delete();
    full_m = 1'b0;
    ptr_m  = 0;
    for (int i = 0; i < NREQ; i++) grants_m[i] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 4'b0101;
    do_reset();
    req_valid = '0;

    // Single request on requester 0
    set_req(0, 32'h0000_0005, 32'h0000_0003);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();

    // Wrap-around on requester 2
    set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    step();

    // Fairness: all requesters valid, consumer always ready
    for (int i = 0; i < NREQ; i++) set_req(i, rand_operand(), rand_operand());
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (last_grant[i]) set_req(i, rand_operand(), rand_operand());
    end

    // Backpressure then simultaneous drain and grant
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();

    // Reset while the result slot is full
    req_valid = '1;
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b1010;
    do_reset();
    rsp_ready = 1'b1;
    step();
    check("first_grant_after_reset", {60'd0, last_grant}, 64'd2);

    // Randomized traffic with random backpressure; requesters hold until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, rand_operand(), rand_operand());
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef ADDER_ARBITER_STATS_EN
    req_valid = '0;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 70000; c++) begin
      set_req(1, $urandom(), $urandom());
      step();
    end
    req_valid = '0;
    step();
    for (int i = 0; i < NREQ; i++) begin
      check("stat_grants", {48'd0, stat_grants[i*16 +: 16]}, 64'(grants_m[i]));
    end
    check("stat_sat1", {48'd0, stat_grants[31:16]}, 64'h0000_FFFF);
`endif

    // Drain everything
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    done = 1'b1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
